cache_arbiter: RTL and testbench

Two-port arbiter that shares one `cache_controller` between two requesters, typically instruction fetch (port 0) and load/store (port 1). The controller has no handshake, so this block issues one command at a time and holds its address and data stable for a fixed access window. It then returns read data with a one-cycle response pulse. Arbitration is round-robin, and there is never more than one access in flight.

---
 rtl/cache_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/cache_arbiter.sv | 144 ++++++++++++++
 tb/tb_cache_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared definitions for the two-port cache arbiter: FSM state encoding,
// requester port ids and a small grant decoding helper.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // A one-hot grant maps to the id of the port that owns bit 1.
  function automatic logic grantToPort(input logic [1:0] grant);
    return grant[1] ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic: a lone requester always wins, a tie goes
// to the port that did not win last time. Purely combinational.
module rr_arb2
  import cache_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last_grant == PORT1) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one handshake-less cache controller between two requesters, issuing
// a single command at a time and holding it for a fixed access window.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  p0_valid,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ready,
  output logic                  p0_resp_valid,
  output logic [DATA_WIDTH-1:0] p0_rdata,

  input  logic                  p1_valid,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ready,
  output logic                  p1_resp_valid,
  output logic [DATA_WIDTH-1:0] p1_rdata,

  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  arb_state_t            r_state;
  arb_state_t            w_nextState;
  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic                  r_port;
  logic                  r_lastGrant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [1:0]            w_grant;
  logic                  w_accept;
  logic                  w_selWe;
  logic [ADDR_WIDTH-1:0] w_selAddr;
  logic [DATA_WIDTH-1:0] w_selWdata;
  logic                  w_lastWait;

  rr_arb2 u_rr_arb2 (
    .i_valid      ({p1_valid, p0_valid}),
    .i_last_grant (r_lastGrant),
    .o_grant      (w_grant)
  );

  assign w_accept   = (r_state == IDLE) && (w_grant != 2'b00);
  assign w_selWe    = w_grant[1] ? p1_we    : p0_we;
  assign w_selAddr  = w_grant[1] ? p1_addr  : p0_addr;
  assign w_selWdata = w_grant[1] ? p1_wdata : p0_wdata;
  assign w_lastWait = (r_state == WAIT) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Ready is gated by reset so nothing looks accepted while reset is held.
  always_comb begin
    w_nextState   = r_state;
    p0_ready      = 1'b0;
    p1_ready      = 1'b0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    case (r_state)
      IDLE: begin
        p0_ready = w_grant[0] && !rst;
        p1_ready = w_grant[1] && !rst;
        if (w_accept) w_nextState = ISSUE;
      end
      ISSUE: begin
        mem_rd      = !r_we;
        mem_wr      = r_we;
        w_nextState = WAIT;
      end
      WAIT: begin
        if (w_lastWait) w_nextState = RESP;
      end
      RESP: begin
        p0_resp_valid = (r_port == PORT0);
        p1_resp_valid = (r_port == PORT1);
        w_nextState   = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Command latches, window counter and read capture; the address and write
  // data registers keep their value after the access until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_port      <= PORT0;
      r_lastGrant <= PORT1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_accept) begin
        r_we        <= w_selWe;
        r_addr      <= w_selAddr;
        r_wdata     <= w_selWdata;
        r_port      <= grantToPort(w_grant);
        r_lastGrant <= grantToPort(w_grant);
      end
      if (r_state == ISSUE) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CNT_LAST;
      end
      if (w_lastWait && !r_we) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign p0_rdata  = r_rdata;
  assign p1_rdata  = r_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of the arbiter.
module tb_cache_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          p0_valid = 1'b0, p1_valid = 1'b0;
  logic          p0_we = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_ready, p1_ready;
  logic          p0_resp_valid, p1_resp_valid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state: who won last, and what the shared read
  // register should currently show.
  logic          modelLastGrant;
  logic [DW-1:0] modelRdata;

  always #5 clk = ~clk;

  cache_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .p0_valid      (p0_valid),
    .p0_we         (p0_we),
    .p0_addr       (p0_addr),
    .p0_wdata      (p0_wdata),
    .p0_ready      (p0_ready),
    .p0_resp_valid (p0_resp_valid),
    .p0_rdata      (p0_rdata),
    .p1_valid      (p1_valid),
    .p1_we         (p1_we),
    .p1_addr       (p1_addr),
    .p1_wdata      (p1_wdata),
    .p1_ready      (p1_ready),
    .p1_resp_valid (p1_resp_valid),
    .p1_rdata      (p1_rdata),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // One complete access, cycle 0 being the IDLE cycle whose edge accepts.
  // Outside IDLE the requester inputs are scrambled with valids held high.
  task automatic doAccess(input string name,
                          input logic v0, input logic v1,
                          input logic we0, input logic we1,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] capData);
    logic          win;
    logic          expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    logic [5:0]    obs, exp;
    win      = (v0 && v1) ? ~modelLastGrant : v1;
    expWe    = win ? we1 : we0;
    expAddr  = win ? a1 : a0;
    expWdata = win ? d1 : d0;
    for (int k = 0; k <= WC + 2; k++) begin
      @(negedge clk);
      if (k == 0) begin
        p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
        p1_valid = v1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
      end else begin
        p0_valid = 1'b1; p0_we = 1'($urandom()); p0_addr = 16'($urandom()); p0_wdata = $urandom();
        p1_valid = 1'b1; p1_we = 1'($urandom()); p1_addr = 16'($urandom()); p1_wdata = $urandom();
      end
      mem_rdata = (k == WC + 1) ? capData : $urandom();
      #1;
      obs = {p1_ready, p0_ready, p1_resp_valid, p0_resp_valid, mem_rd, mem_wr};
      exp = {(k == 0) && win, (k == 0) && !win,
             (k == WC + 2) && win, (k == WC + 2) && !win,
             (k == 1) && !expWe, (k == 1) && expWe};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL %s handshake k=%0d got %b want %b", name, k, obs, exp);
      end
      if (k >= 1) begin
        checks++;
        if (mem_addr !== expAddr || mem_wdata !== expWdata) begin
          errors++;
          $display("[TB] FAIL %s mem_cmd k=%0d got %h/%h want %h/%h",
                   name, k, mem_addr, mem_wdata, expAddr, expWdata);
        end
      end
      if (k == WC + 2) begin
        checks++;
        if (p0_rdata !== modelRdata || p1_rdata !== modelRdata) begin
          errors++;
          $display("[TB] FAIL %s rdata got %h/%h want %h", name, p0_rdata, p1_rdata, modelRdata);
        end
      end
      if (k == 0) modelLastGrant = win;
      if (k == WC + 1 && !expWe) modelRdata = capData;
    end
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    p0_valid = 1'b1; p1_valid = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    obs = {p1_ready, p0_ready, p1_resp_valid, p0_resp_valid, mem_rd, mem_wr};
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want 000000", obs);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || p0_rdata !== '0 || p1_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h/%h/%h/%h want zeros", mem_addr, mem_wdata, p0_rdata, p1_rdata);
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    rst = 1'b0;
    modelLastGrant = 1'b1;
    modelRdata = '0;
  endtask

  task automatic test_idle(input int n);
    logic [5:0] obs;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      p0_valid = 1'b0; p0_we = 1'($urandom()); p0_addr = 16'($urandom());
      p1_valid = 1'b0; p1_we = 1'($urandom()); p1_addr = 16'($urandom());
      #1;
      obs = {p1_ready, p0_ready, p1_resp_valid, p0_resp_valid, mem_rd, mem_wr};
      checks++;
      if (obs !== 6'b0) begin
        errors++;
        $display("[TB] FAIL idle cycle=%0d got %b want 000000", i, obs);
      end
    end
  endtask

  task automatic test_read_p0();
    doAccess("p0_read", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'($urandom()),
             $urandom(), $urandom(), 32'hDEADBEEF);
  endtask

  task automatic test_write_p1();
    doAccess("p1_write", 1'b0, 1'b1, 1'b0, 1'b1, 16'($urandom()), 16'h0020,
             $urandom(), 32'h12345678, 32'hA5A5A5A5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      doAccess("b2b", 1'b1, 1'b1, 1'($urandom()), 1'($urandom()),
               16'($urandom()), 16'($urandom()), $urandom(), $urandom(), $urandom());
    end
  endtask

  // p1 is held valid through p0's whole access and must be taken in the very
  // next IDLE cycle.
  task automatic test_holdoff();
    doAccess("holdoff_p0", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0200,
             $urandom(), $urandom(), $urandom());
    doAccess("holdoff_p1", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0200,
             $urandom(), $urandom(), $urandom());
  endtask

  task automatic test_mid_reset();
    logic [5:0] obs;
    @(negedge clk);
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 16'h0BAD; p1_valid = 1'b0;
    @(negedge clk);
    p0_valid = 1'b0;
    @(negedge clk);
    mem_rdata = 32'hCAFEF00D;
    #1 rst = 1'b1;
    #1;
    obs = {p1_ready, p0_ready, p1_resp_valid, p0_resp_valid, mem_rd, mem_wr};
    checks++;
    if (obs !== 6'b0 || mem_addr !== '0 || p0_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset got %b addr %h rdata %h want zeros", obs, mem_addr, p0_rdata);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelLastGrant = 1'b1;
    modelRdata = '0;
    test_idle(WC + 3);
    doAccess("post_reset_tie", 1'b1, 1'b1, 1'b0, 1'b1, 16'h0301, 16'h0302,
             $urandom(), $urandom(), $urandom());
  endtask

  task automatic test_random();
    logic v0, v1;
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom());
      v1 = 1'($urandom());
      if (!v0 && !v1) v0 = 1'b1;
      doAccess("random", v0, v1, 1'($urandom()), 1'($urandom()),
               16'($urandom()), 16'($urandom()), $urandom(), $urandom(), $urandom());
      test_idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    modelLastGrant = 1'b1;
    modelRdata = '0;
    test_reset();
    test_idle(2);
    test_read_p0();
    test_write_p1();
    test_back_to_back();
    test_holdoff();
    test_idle(3);
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
